dilated_window_mac: RTL and testbench

- 3x3 dilated depthwise MAC stage, directly downstream of the dilated line/shift RAM.
- Consumes one 3-row tap column per accepted cycle and keeps a column history.
- Forms a 3x3 window with horizontal spacing 1, 2 or 4 and multiplies it by nine locally stored signed weights.
- Emits one bias-added partial sum per complete window to the output accumulation/requantise stage.

---
 rtl/dilated_window_mac.sv | 142 ++++++++++++++
 tb/tb_dilated_window_mac.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dilated_window_mac.sv
// dilated_window_mac: 3x3 dilated depthwise MAC over a column history, two-stage product/sum pipeline.
// Optional DILATED_WINDOW_MAC_RELU_EN clamps negative partial sums to zero.
module dilated_window_mac #(
    parameter int DATA_WIDTH   = 8,
    parameter int TAP_NUMBER   = 3,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 20,
    parameter int HIST_DEPTH   = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             clear,
    input  logic [1:0]                       dilation_sel_i,
    input  logic                             weight_load_i,
    input  logic [WEIGHT_WIDTH-1:0]          weight_data_i,
    output logic                             weight_ready_o,
    input  logic                             tap_data_valid_i,
    input  logic [TAP_NUMBER*DATA_WIDTH-1:0] tap_data_i,
    input  logic [ACC_WIDTH-1:0]             bias_i,
    output logic                             psum_valid_o,
    output logic [ACC_WIDTH-1:0]             psum_data_o,
    output logic                             busy_o
);
    localparam int PW    = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int CW    = TAP_NUMBER * DATA_WIDTH;
    localparam int CNT_W = $clog2(HIST_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN} state_t;
    state_t state, state_nx;

    logic signed [WEIGHT_WIDTH-1:0] weight [9];
    logic [3:0]                     w_idx;
    logic                           weights_loaded;
    logic [CW-1:0]                  hist [HIST_DEPTH];
    logic [CNT_W-1:0]               col_cnt, cnt_nx, need;
    logic [2:0]                     d;
    logic [3:0]                     cidx [3];
    logic                           accept, win_ok, win_v, s1_v, wr;
    logic [ACC_WIDTH-1:0]           win_bias, s1_bias, sum, result;
    logic signed [PW-1:0]           prod [9];
    logic signed [PW-1:0]           s1_prod [9];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = weight_load_i ? LOAD_W : (en && weights_loaded) ? RUN : IDLE;
            LOAD_W:  state_nx = (weight_load_i && w_idx == 4'd8) ? IDLE : LOAD_W;
            RUN:     state_nx = (!en || clear) ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        weight_ready_o = (state == IDLE) || (state == LOAD_W);
        busy_o         = (state == RUN) || win_v || s1_v || psum_valid_o;
    end

    // The strobe that moves IDLE to LOAD_W already carries weight 0.
    assign wr = weight_ready_o && weight_load_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) weight[k] <= '0;
            w_idx          <= '0;
            weights_loaded <= 1'b0;
        end else if (wr) begin
            weight[w_idx]  <= weight_data_i;
            w_idx          <= (w_idx == 4'd8) ? 4'd0 : w_idx + 4'd1;
            weights_loaded <= weights_loaded || (w_idx == 4'd8);
        end
    end

    assign accept = (state == RUN) && en && tap_data_valid_i && !clear;
    assign cnt_nx = (col_cnt == CNT_W'(HIST_DEPTH)) ? col_cnt : col_cnt + 1'b1;
    assign d      = (dilation_sel_i == 2'b00) ? 3'd1 : (dilation_sel_i == 2'b01) ? 3'd2 : 3'd4;
    assign need   = CNT_W'({d, 1'b1});
    assign win_ok = accept && (dilation_sel_i != 2'b11) && (cnt_nx >= need);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            hist[0] <= tap_data_i;
            for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
            col_cnt <= cnt_nx;
        end
    end

    // Window taps come from the already-shifted history, one cycle after the accept.
    assign cidx[2] = 4'd0;
    assign cidx[1] = {1'b0, d};
    assign cidx[0] = {d, 1'b0};

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign prod[r*3+c] = $signed(hist[cidx[c]][r*DATA_WIDTH +: DATA_WIDTH]) * weight[r*3+c];
        end
    end

    always_comb begin
        sum = s1_bias;
        for (int k = 0; k < 9; k++) sum = sum + {{(ACC_WIDTH-PW){s1_prod[k][PW-1]}}, s1_prod[k]};
`ifdef DILATED_WINDOW_MAC_RELU_EN
        result = sum[ACC_WIDTH-1] ? '0 : sum;
`else
        result = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win_v        <= 1'b0;
            s1_v         <= 1'b0;
            psum_valid_o <= 1'b0;
        end else begin
            win_v        <= win_ok;
            s1_v         <= win_v;
            psum_valid_o <= s1_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) s1_prod[k] <= '0;
            win_bias    <= '0;
            s1_bias     <= '0;
            psum_data_o <= '0;
        end else begin
            if (win_ok) win_bias <= bias_i;
            for (int k = 0; k < 9; k++) s1_prod[k] <= prod[k];
            s1_bias <= win_bias;
            if (s1_v) psum_data_o <= result;
        end
    end
endmodule

// File: tb/tb_dilated_window_mac.sv
// tb_dilated_window_mac: directed table-driven checks of the dilated 3x3 MAC stage.
module tb_dilated_window_mac;
    logic        clk = 0, rst = 1, en = 0, clear = 0;
    logic [1:0]  dilation_sel_i = 2'b00;
    logic        weight_load_i = 0;
    logic [7:0]  weight_data_i = '0;
    logic        weight_ready_o;
    logic        tap_data_valid_i = 0;
    logic [23:0] tap_data_i = '0;
    logic [19:0] bias_i = '0;
    logic        psum_valid_o;
    logic [19:0] psum_data_o;
    logic        busy_o;
    int          total = 0, bad = 0;

    dilated_window_mac dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .dilation_sel_i(dilation_sel_i),
        .weight_load_i(weight_load_i), .weight_data_i(weight_data_i), .weight_ready_o(weight_ready_o),
        .tap_data_valid_i(tap_data_valid_i), .tap_data_i(tap_data_i), .bias_i(bias_i),
        .psum_valid_o(psum_valid_o), .psum_data_o(psum_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] w;
        logic [1:0]  sel;
        logic [23:0] tap;
        logic [19:0] bias;
        logic        ramp;
        int          first;
        int          n;
        logic [19:0] exp;
        logic [19:0] inc;
    } vec_t;

    vec_t tv [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_case(input int id, input vec_t c);
        logic [19:0] e;
        en = 0; dilation_sel_i = c.sel; clear = 1;
        step();
        clear = 0;
        for (int k = 0; k < 9; k++) begin
            weight_load_i = 1; weight_data_i = c.w[k*8 +: 8];
            step();
        end
        weight_load_i = 0;
        bias_i = c.bias; en = 1;
        step();
        chk($sformatf("case%0d_run_busy", id), {31'b0, busy_o}, 32'd1);
        e = c.exp;
        for (int s = 1; s <= c.n + 3; s++) begin
            tap_data_valid_i = (s <= c.n);
            tap_data_i = c.ramp ? {3{8'(s)}} : c.tap;
            step();
            if (c.first != 0 && s - 2 >= c.first && s - 2 <= c.n) begin
                chk($sformatf("case%0d_valid_s%0d", id, s), {31'b0, psum_valid_o}, 32'd1);
                chk($sformatf("case%0d_psum_s%0d", id, s), {12'b0, psum_data_o}, {12'b0, e});
                e = e + c.inc;
            end else begin
                chk($sformatf("case%0d_novalid_s%0d", id, s), {31'b0, psum_valid_o}, 32'd0);
            end
        end
        tap_data_valid_i = 0; en = 0;
        step();
    endtask

    initial begin
        tv[0] = '{w: {9{8'h01}}, sel: 2'b00, tap: {8'd3, 8'd2, 8'd1}, bias: 20'd0, ramp: 1'b0,
                  first: 3, n: 5, exp: 20'd18, inc: 20'd0};
        tv[1] = '{w: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, sel: 2'b01, tap: 24'd0,
                  bias: 20'd0, ramp: 1'b1, first: 5, n: 7, exp: 20'd120, inc: 20'd36};
        tv[2] = '{w: {9{8'h80}}, sel: 2'b10, tap: 24'h808080, bias: 20'd0, ramp: 1'b0,
                  first: 9, n: 11, exp: 20'd147456, inc: 20'd0};
`ifdef DILATED_WINDOW_MAC_RELU_EN
        tv[3] = '{w: {9{8'hFF}}, sel: 2'b00, tap: 24'h050505, bias: 20'd10, ramp: 1'b0,
                  first: 3, n: 5, exp: 20'h00000, inc: 20'd0};
`else
        tv[3] = '{w: {9{8'hFF}}, sel: 2'b00, tap: 24'h050505, bias: 20'd10, ramp: 1'b0,
                  first: 3, n: 5, exp: 20'hFFFDD, inc: 20'd0};
`endif
        tv[4] = '{w: {9{8'h01}}, sel: 2'b11, tap: {8'd3, 8'd2, 8'd1}, bias: 20'd0, ramp: 1'b0,
                  first: 0, n: 9, exp: 20'd0, inc: 20'd0};

        step(); step();
        rst = 0;
        step();
        chk("rst_valid", {31'b0, psum_valid_o}, 32'd0);
        chk("rst_data", {12'b0, psum_data_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_ready", {31'b0, weight_ready_o}, 32'd1);

        // en held with no weights loaded: stay in IDLE, nothing accepted
        en = 1; tap_data_valid_i = 1; tap_data_i = {8'd3, 8'd2, 8'd1};
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("noweights_busy%0d", i), {31'b0, busy_o}, 32'd0);
            chk($sformatf("noweights_valid%0d", i), {31'b0, psum_valid_o}, 32'd0);
        end
        tap_data_valid_i = 0;

        // gapped weight load, en kept high the whole time
        for (int k = 0; k < 9; k++) begin
            weight_load_i = 1; weight_data_i = 8'h01;
            step();
            weight_load_i = 0;
            step();
            if (k < 8) chk($sformatf("load_gap_busy%0d", k), {31'b0, busy_o}, 32'd0);
        end
        step();
        chk("loaded_run_busy", {31'b0, busy_o}, 32'd1);
        chk("loaded_run_ready", {31'b0, weight_ready_o}, 32'd0);

        // two taps then clear (coinciding with a tap, which must be dropped)
        tap_data_valid_i = 1;
        step(); step();
        clear = 1; en = 0;
        step();
        clear = 0; tap_data_valid_i = 0;
        chk("clear_busy", {31'b0, busy_o}, 32'd0);
        chk("clear_valid", {31'b0, psum_valid_o}, 32'd0);
        en = 1;
        step();
        for (int s = 1; s <= 6; s++) begin
            tap_data_valid_i = (s <= 3);
            step();
            chk($sformatf("clear_seq_valid_s%0d", s), {31'b0, psum_valid_o}, (s == 5) ? 32'd1 : 32'd0);
            if (s == 5) chk("clear_seq_psum", {12'b0, psum_data_o}, 32'd18);
        end
        en = 0; tap_data_valid_i = 0;
        step(); step();

        for (int i = 0; i < 5; i++) run_case(i, tv[i]);
        chk("final_busy", {31'b0, busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
